// File: rtl/move_stack.sv
// move_stack: per-ply LIFO move-list server for the depth-first traversal.
// Optional MOVE_STACK_STATS_EN adds peak_occupancy and drop_count outputs.
module move_stack #(
   parameter int MOVE_W  = 16,
   parameter int DEPTH   = 256,
   parameter int MAX_PLY = 16,
   localparam int AW     = $clog2(DEPTH),
   localparam int PW     = $clog2(MAX_PLY + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [MOVE_W-1:0] cmd_move,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [MOVE_W-1:0] rsp_move,
   output logic              rsp_end,
   output logic [AW:0]       frame_count,
   output logic [PW-1:0]     ply,
   output logic              full,
`ifdef MOVE_STACK_STATS_EN
   output logic [AW:0]       peak_occupancy,
   output logic [15:0]       drop_count,
`endif
   output logic              err_overflow,
   output logic              err_ply,
   output logic              err_underflow
);

   typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

   localparam logic [1:0] OP_PUSH  = 2'd0;
   localparam logic [1:0] OP_OPEN  = 2'd1;
   localparam logic [1:0] OP_NEXT  = 2'd2;
   localparam logic [1:0] OP_CLOSE = 2'd3;

   state_t state_q, state_d;

   logic [MOVE_W-1:0] mem [DEPTH];
   logic [AW:0]       base   [MAX_PLY+1];
   logic [AW:0]       cursor [MAX_PLY+1];
   logic [AW:0]       wr_ptr;
   logic [AW-1:0]     rd_addr;
   logic [PW-1:0]     ply_up;

   logic accept, avail, top_open, at_max;
   logic do_push, push_drop, do_open, open_drop;
   logic do_close, close_drop, do_next;

   assign accept     = cmd_valid && cmd_ready;
   assign top_open   = (ply != '0);
   assign at_max     = (ply == PW'(MAX_PLY));
   assign ply_up     = ply + 1'b1;
   assign avail      = top_open && (cursor[ply] < wr_ptr);
   assign full       = (wr_ptr == (AW+1)'(DEPTH));
   assign frame_count = top_open ? (wr_ptr - base[ply]) : '0;

   assign do_push    = accept && cmd_op == OP_PUSH && !full && top_open;
   assign push_drop  = accept && cmd_op == OP_PUSH && (full || !top_open);
   assign do_open    = accept && cmd_op == OP_OPEN && !at_max;
   assign open_drop  = accept && cmd_op == OP_OPEN && at_max;
   assign do_close   = accept && cmd_op == OP_CLOSE && top_open;
   assign close_drop = accept && cmd_op == OP_CLOSE && !top_open;
   assign do_next    = accept && cmd_op == OP_NEXT;

   // State register for the response FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && cmd_op == OP_NEXT)
               state_d = avail ? READ : RESP;
         end
         READ: state_d = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Move storage and per-frame base/cursor; not reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= cmd_move;
      if (do_open) begin
         base[ply_up]   <= wr_ptr;
         cursor[ply_up] <= wr_ptr;
      end
      if (do_next && avail) cursor[ply] <= cursor[ply] + 1'b1;
   end

   // Stack pointers, response data and sticky error flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         ply           <= '0;
         rd_addr       <= '0;
         rsp_move      <= '0;
         rsp_end       <= 1'b0;
         err_overflow  <= 1'b0;
         err_ply       <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (do_push)    wr_ptr <= wr_ptr + 1'b1;
         if (push_drop)  err_overflow <= 1'b1;
         if (do_open)    ply <= ply_up;
         if (open_drop)  err_ply <= 1'b1;
         if (do_close) begin
            wr_ptr <= base[ply];
            ply    <= ply - 1'b1;
         end
         if (close_drop) err_underflow <= 1'b1;
         if (do_next) begin
            if (avail) begin
               rd_addr <= cursor[ply][AW-1:0];
            end else begin
               rsp_move <= '0;
               rsp_end  <= 1'b1;
            end
         end
         if (state_q == READ) begin
            rsp_move <= mem[rd_addr];
            rsp_end  <= 1'b0;
         end
      end
   end

`ifdef MOVE_STACK_STATS_EN
   // High-water mark of the stack and saturating dropped-PUSH count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         peak_occupancy <= '0;
         drop_count     <= '0;
      end else begin
         if (wr_ptr > peak_occupancy) peak_occupancy <= wr_ptr;
         if (push_drop && drop_count != 16'hFFFF)
            drop_count <= drop_count + 1'b1;
      end
   end
`endif

endmodule

// File: doc/move_stack.md
# move_stack

Hardware move-list server for the search/perft traversal. It stores the legal moves produced by the move generator in per-ply frames on a single LIFO memory. It hands them back one at a time to the depth-first traversal controller, which is the initiator issuing make/undo sequences. It also reports the top frame's move count, so a depth-1 leaf needs no iteration.

## Interface
- MOVE_W, 16: move encoding width (from[5:0], to[11:6], promo/flags[15:12]).
- DEPTH, 256: total move entries across all frames; power of two.
- MAX_PLY, 16: maximum simultaneously open frames.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  0 PUSH, 1 OPEN, 2 NEXT, 3 CLOSE.
- cmd_move  in  MOVE_W  move payload for PUSH.
- rsp_valid  out  1  NEXT response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_move  out  MOVE_W  returned move; 0 when rsp_end.
- rsp_end  out  1  top frame exhausted, or no frame open.
- frame_count  out  clog2(DEPTH)+1  entries in top frame (wr_ptr − base[ply]); 0 at ply 0.
- ply  out  clog2(MAX_PLY+1)  number of open frames.
- full  out  1  wr_ptr == DEPTH.
- err_overflow, err_ply, err_underflow  out  1 each  sticky error flags, cleared only by reset.

## Operation
- State: wr_ptr, ply, base[1..MAX_PLY], cursor[1..MAX_PLY], FSM {IDLE, READ, RESP}.
- OPEN: base[ply+1] ← wr_ptr; cursor[ply+1] ← wr_ptr; ply++. If ply == MAX_PLY, the command is ignored and err_ply is set.
- PUSH: mem[wr_ptr] ← cmd_move; wr_ptr++. It always targets the top frame. If full, or if ply == 0, the move is dropped and err_overflow is set.
- NEXT: if ply ≥ 1 and cursor[ply] < wr_ptr, read mem[cursor[ply]] and cursor[ply]++; otherwise respond with rsp_end=1, rsp_move=0.
- CLOSE: wr_ptr ← base[ply]; ply--. This discards all unread and read entries of the frame. At ply 0 it is ignored and err_underflow is set.
- FSM: IDLE accepts any op.
  - NEXT with a move available → READ (memory read cycle) → RESP.
  - NEXT that returns end → RESP directly.
  - RESP holds until rsp_ready, then → IDLE.
- PUSH/OPEN/CLOSE complete in IDLE in one cycle, with no response.
- Parent frames are untouched while a child is open. After CLOSE, NEXT resumes the parent at its saved cursor, which matches the make/recurse/undo loop.
- frame_count and full are combinational from registered state.

## Timing
- Reset (rst_n low at a clock edge): wr_ptr=0, ply=0, FSM=IDLE, rsp_valid=0, rsp_move=0, rsp_end=0, frame_count=0, full=0, all error flags 0, cmd_ready=1 on the first cycle after release. Memory contents are undefined; base/cursor arrays need not be reset.
- cmd_ready=1 only in IDLE.
- NEXT latency:
  - with a move: accepted at cycle N, rsp_valid asserted at N+2.
  - with end: rsp_valid asserted at N+1.
- rsp_valid, rsp_move and rsp_end stay stable until the handshake. rsp_valid deasserts the cycle after the handshake. The next command is accepted at the earliest in the cycle after that handshake.
- PUSH/OPEN/CLOSE: state is visible the cycle after acceptance. Back-to-back PUSHes sustain 1 per cycle.
- Reset asserted during READ/RESP aborts the response: no rsp_valid after reset, and the cursor increment has already committed but is discarded by the reset.
- Boundaries:
  - PUSH when wr_ptr == DEPTH−1 succeeds and full rises.
  - The next PUSH drops and sets err_overflow; wr_ptr stays at DEPTH.

## Configuration
- MOVE_STACK_STATS_EN defined: adds outputs peak_occupancy (clog2(DEPTH)+1, max wr_ptr since reset) and drop_count (16 bits, saturating count of dropped PUSHes), both reset to 0.
- Undefined: neither port exists, and no logic is inferred for them. Core behaviour is identical in both builds.

## Test plan
- Reset, then OPEN, PUSH 0x1234, 0x0567, 0x0E9A: frame_count=3, ply=1. Three NEXTs return those moves in push order with rsp_end=0. A fourth NEXT returns rsp_end=1, rsp_move=0.
- Nested frames:
  - OPEN, PUSH A,B; NEXT→A; OPEN, PUSH C; NEXT→C; CLOSE; NEXT→B; NEXT→end.
  - frame_count is 1 inside the child frame and 2 after CLOSE.
- Backpressure: hold rsp_ready=0 for 5 cycles after a NEXT. rsp_valid stays 1 with a stable move, cmd_ready stays 0, and exactly one cursor advance occurs.
- Overflow with DEPTH=4: OPEN plus 5 PUSHes. full=1 after the 4th, the 5th is dropped, err_overflow=1, and drop_count=1 when MOVE_STACK_STATS_EN is defined.
- Errors:
  - CLOSE at ply 0 → err_underflow=1, with wr_ptr and ply unchanged.
  - MAX_PLY+1 OPENs → err_ply=1, ply=MAX_PLY.
  - NEXT at ply 0 → rsp_end=1.
- Assert rst_n low during RESP → the following cycle shows rsp_valid=0, ply=0, frame_count=0, cmd_ready=1.
